// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pong_game_ctrl
//
// Top-level game sequencer for two-player pong. Gates the paddle and ball
// movers, requests ball re-centring, keeps both scores and decides the serve
// direction and the winner from ball-miss events. All timing is counted in
// video frames via frame_tick.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start_btn    synchronised start/restart button level
//   miss_left    one-cycle pulse: ball passed left paddle (right scores)
//   miss_right   one-cycle pulse: ball passed right paddle (left scores)
//   paddle_en    paddle movement enable
//   ball_en      ball motion enable
//   ball_rst     one-cycle pulse: re-centre the ball
//   serve_dir    launch x-direction, 0 = toward left, 1 = toward right
//   score_left   left player score
//   score_right  right player score
//   game_over    high while the game is over
//   winner       0 = left, 1 = right; meaningful while game_over = 1
//   state        current state encoding (IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4)
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90,
  parameter int SCORE_WIDTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   start_btn,
  input  logic                   miss_left,
  input  logic                   miss_right,
  output logic                   paddle_en,
  output logic                   ball_en,
  output logic                   ball_rst,
  output logic                   serve_dir,
  output logic [SCORE_WIDTH-1:0] score_left,
  output logic [SCORE_WIDTH-1:0] score_right,
  output logic                   game_over,
  output logic                   winner,
  output logic [2:0]             state
);

  // Frame counter must hold the longer of the two waits.
  localparam int MAX_FRAMES = (SERVE_DELAY_FRAMES > POINT_HOLD_FRAMES) ?
                              SERVE_DELAY_FRAMES : POINT_HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]       SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0]       POINT_LAST = CNT_W'(POINT_HOLD_FRAMES - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Registered state and outputs
  state_e                 state_q,       state_d;
  logic [CNT_W-1:0]       frame_cnt_q,   frame_cnt_d;
  logic [SCORE_WIDTH-1:0] score_left_q,  score_left_d;
  logic [SCORE_WIDTH-1:0] score_right_q, score_right_d;
  logic                   serve_dir_q,   serve_dir_d;
  logic                   winner_q,      winner_d;
  logic                   game_over_q,   game_over_d;
  logic                   paddle_en_q,   paddle_en_d;
  logic                   ball_en_q,     ball_en_d;
  logic                   ball_rst_q,    ball_rst_d;
  logic                   start_q,       start_d;

  logic                   start_fire;
  logic [SCORE_WIDTH-1:0] score_left_inc;
  logic [SCORE_WIDTH-1:0] score_right_inc;

  // Rising edge of the start button: holding it fires exactly once.
  assign start_fire      = start_btn & ~start_q;
  assign score_left_inc  = score_left_q  + SCORE_ONE;
  assign score_right_inc = score_right_q + SCORE_ONE;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    frame_cnt_d   = '0;       // counter is 0 outside SERVE and POINT
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    serve_dir_d   = serve_dir_q;
    winner_d      = winner_q;
    ball_rst_d    = 1'b0;
    start_d       = start_btn;

    case (state_q)
      // IDLE and OVER both wait for a start edge and begin a fresh game.
      ST_IDLE, ST_OVER: begin
        if (start_fire) begin
          score_left_d  = '0;
          score_right_d = '0;
          serve_dir_d   = 1'b1;
          ball_rst_d    = 1'b1;
          state_d       = ST_SERVE;
        end
      end

      ST_SERVE: begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
          if (frame_cnt_q == SERVE_LAST) begin
            frame_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
          end
        end
      end

      ST_PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses are a replay: no score, straight back to serve.
          ball_rst_d = 1'b1;
          state_d    = ST_SERVE;
        end else if (miss_left) begin
          score_right_d = score_right_inc;
          serve_dir_d   = 1'b0;
          if (score_right_inc == WIN_VAL) begin
            winner_d = 1'b1;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_POINT;
          end
        end else if (miss_right) begin
          score_left_d = score_left_inc;
          serve_dir_d  = 1'b1;
          if (score_left_inc == WIN_VAL) begin
            winner_d = 1'b0;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
          if (frame_cnt_q == POINT_LAST) begin
            frame_cnt_d = '0;
            ball_rst_d  = 1'b1;
            state_d     = ST_SERVE;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enables follow the state being entered so they are registered alongside
    // it: they rise and fall on the same edge as the state change.
    paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      score_left_q  <= '0;
      score_right_q <= '0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 1'b0;
      game_over_q   <= 1'b0;
      paddle_en_q   <= 1'b0;
      ball_en_q     <= 1'b0;
      ball_rst_q    <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      paddle_en_q   <= paddle_en_d;
      ball_en_q     <= ball_en_d;
      ball_rst_q    <= ball_rst_d;
      start_q       <= start_d;
    end
  end

  assign paddle_en   = paddle_en_q;
  assign ball_en     = ball_en_q;
  assign ball_rst    = ball_rst_q;
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
